// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA raster constants, coordinate types and decode helpers for the timing generator.
// The frame counter is built only when VGA_FRAME_CNT_EN is defined.
package vga_pkg;

    localparam int COORD_W     = 10;
    localparam int FRAME_CNT_W = 16;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [COORD_W-1:0]     coord_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    typedef struct packed {
        logic   de;
        logic   hsync;
        logic   vsync;
        logic   line_start;
        logic   frame_start;
        coord_t x;
        coord_t y;
    } raster_t;

    // Syncs idle high, so the reset image is not all-zero.
    localparam raster_t RASTER_RESET = '{
        de:          1'b0,
        hsync:       1'b1,
        vsync:       1'b1,
        line_start:  1'b0,
        frame_start: 1'b0,
        x:           '0,
        y:           '0
    };

    function automatic logic in_window(coord_t val, coord_t lo, coord_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen; the generator drives master, consumers use slave.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       pix_ce;
    logic       de;
    coord_t     x;
    coord_t     y;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       line_start;
    frame_cnt_t frame_cnt;

    modport master (
        output pix_ce, de, x, y, hsync, vsync, frame_start, line_start, frame_cnt
    );

    modport slave (
        input pix_ce, de, x, y, hsync, vsync, frame_start, line_start, frame_cnt
    );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Reusable clock-enable divider: tick is high for one clk out of every CLK_DIV.
// With CLK_DIV=1 the counter never leaves 0, so tick is permanently asserted.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign tick = (r_div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate counters, decode and registered outputs.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to 0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic    w_tick;
    coord_t  r_h_cnt;
    coord_t  r_v_cnt;
    raster_t w_decode;
    raster_t r_out;
    logic    r_pix_ce;
    logic    w_at_origin;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign w_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_comb begin
        w_decode             = RASTER_RESET;
        w_decode.x           = r_h_cnt;
        w_decode.y           = r_v_cnt;
        w_decode.de          = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
        w_decode.hsync       = !in_window(r_h_cnt, HS_START, HS_END);
        w_decode.vsync       = !in_window(r_v_cnt, VS_START, VS_END);
        w_decode.line_start  = (r_h_cnt == '0);
        w_decode.frame_start = w_at_origin;
    end

    // Outputs load on the tick edge, so pix_ce registered from the tick lines up with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out    <= RASTER_RESET;
            r_pix_ce <= 1'b0;
        end else begin
            r_pix_ce <= w_tick;
            if (w_tick) begin
                r_out <= w_decode;
            end
        end
    end

    assign vga.pix_ce      = r_pix_ce;
    assign vga.de          = r_out.de;
    assign vga.x           = r_out.x;
    assign vga.y           = r_out.y;
    assign vga.hsync       = r_out.hsync;
    assign vga.vsync       = r_out.vsync;
    assign vga.line_start  = r_out.line_start;
    assign vga.frame_start = r_out.frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic       r_first_seen;
    frame_cnt_t r_frame_cnt;

    // The first origin after reset only arms the counter, so frame one reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first_seen <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (w_tick && w_at_origin) begin
            r_first_seen <= 1'b1;
            if (r_first_seen) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign vga.frame_cnt = r_frame_cnt;
`else
    assign vga.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default-geometry instance for line timing and reset,
// plus a tiny-geometry CLK_DIV=1 instance for frame wrap, sync windows and frame_cnt.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic resetMain_n;
    logic resetSmall_n;

    always #5 clk = ~clk;

    vga_timing_gen_if vgaMain ();
    vga_timing_gen_if vgaSmall ();

    vga_timing_gen #(
        .CLK_DIV (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (resetMain_n),
        .vga     (vgaMain.master)
    );

    // Tiny raster: H 8+2+3+2 = 15, V 6+1+2+1 = 10, one frame = 150 clks.
    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) u_small (
        .clk     (clk),
        .reset_n (resetSmall_n),
        .vga     (vgaSmall.master)
    );

    typedef struct {
        int         pulse;
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hsync;
        logic       vsync;
        logic       lineStart;
        logic       frameStart;
    } vec_t;

    vec_t vecTable[$];

    int vectorsApplied = 0;
    int miscompares    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstMain, input logic rstSmall);
        @(negedge clk);
        resetMain_n  = rstMain;
        resetSmall_n = rstSmall;
    endtask

    function automatic void addVec(int p, int xv, int yv, logic d, logic hs, logic vs, logic ls, logic fs);
        vec_t v;
        v.pulse = p; v.x = 10'(xv); v.y = 10'(yv);
        v.de = d; v.hsync = hs; v.vsync = vs; v.lineStart = ls; v.frameStart = fs;
        vecTable.push_back(v);
    endfunction

    task automatic compareVec(input vec_t v);
        checkOutput($sformatf("p%0d x", v.pulse), 32'(vgaMain.x), 32'(v.x));
        checkOutput($sformatf("p%0d y", v.pulse), 32'(vgaMain.y), 32'(v.y));
        checkOutput($sformatf("p%0d de", v.pulse), 32'(vgaMain.de), 32'(v.de));
        checkOutput($sformatf("p%0d hsync", v.pulse), 32'(vgaMain.hsync), 32'(v.hsync));
        checkOutput($sformatf("p%0d vsync", v.pulse), 32'(vgaMain.vsync), 32'(v.vsync));
        checkOutput($sformatf("p%0d line_start", v.pulse), 32'(vgaMain.line_start), 32'(v.lineStart));
        checkOutput($sformatf("p%0d frame_start", v.pulse), 32'(vgaMain.frame_start), 32'(v.frameStart));
    endtask

    // Advances to the next clk where the main instance shows pix_ce=1, bounded.
    task automatic nextPixel(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (vgaMain.pix_ce === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " pix_ce"}, 32'(vgaMain.pix_ce), 32'd0);
        checkOutput({tag, " de"}, 32'(vgaMain.de), 32'd0);
        checkOutput({tag, " x"}, 32'(vgaMain.x), 32'd0);
        checkOutput({tag, " y"}, 32'(vgaMain.y), 32'd0);
        checkOutput({tag, " hsync"}, 32'(vgaMain.hsync), 32'd1);
        checkOutput({tag, " vsync"}, 32'(vgaMain.vsync), 32'd1);
        checkOutput({tag, " frame_start"}, 32'(vgaMain.frame_start), 32'd0);
        checkOutput({tag, " line_start"}, 32'(vgaMain.line_start), 32'd0);
        checkOutput({tag, " frame_cnt"}, 32'(vgaMain.frame_cnt), 32'd0);
    endtask

    int cyc;
    bit ok;
    int vi;
    int spacingErr;
    int hsLow;
    int deCnt;
    int rasterErr;
    int ceErr;
    int fsCnt;
    int vsLow;
    int h;
    int v;
    int expFc;
    logic expDe, expHs, expVs, expLs, expFs;

    initial begin
        resetMain_n  = 1'b0;
        resetSmall_n = 1'b0;

        addVec(0,    0,   0, 1, 1, 1, 1, 1);
        addVec(1,    1,   0, 1, 1, 1, 0, 0);
        addVec(639,  639, 0, 1, 1, 1, 0, 0);
        addVec(640,  640, 0, 0, 1, 1, 0, 0);
        addVec(655,  655, 0, 0, 1, 1, 0, 0);
        addVec(656,  656, 0, 0, 0, 1, 0, 0);
        addVec(751,  751, 0, 0, 0, 1, 0, 0);
        addVec(752,  752, 0, 0, 1, 1, 0, 0);
        addVec(799,  799, 0, 0, 1, 1, 0, 0);
        addVec(800,  0,   1, 1, 1, 1, 1, 0);
        addVec(801,  1,   1, 1, 1, 1, 0, 0);
        addVec(1439, 639, 1, 1, 1, 1, 0, 0);
        addVec(1440, 640, 1, 0, 1, 1, 0, 0);
        addVec(1900, 300, 2, 1, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");

        applyStimulus(1'b1, 1'b0);
        vi = 0; spacingErr = 0; hsLow = 0; deCnt = 0;
        for (int p = 0; p <= 1900; p++) begin
            nextPixel(cyc, ok);
            if (!ok) begin
                checkOutput("pix_ce timeout", 32'd0, 32'd1);
                break;
            end
            if (p == 0) checkOutput("first pix_ce latency", 32'(cyc), 32'd4);
            else if (cyc != 4) spacingErr++;
            if (p < 800) begin
                if (vgaMain.hsync == 1'b0) hsLow++;
                if (vgaMain.de == 1'b1) deCnt++;
            end
            if (vi < vecTable.size() && vecTable[vi].pulse == p) begin
                compareVec(vecTable[vi]);
                vi++;
            end
        end
        checkOutput("table vectors reached", 32'(vi), 32'(vecTable.size()));
        checkOutput("pix_ce spacing errors", 32'(spacingErr), 32'd0);
        checkOutput("hsync low ticks per line", 32'(hsLow), 32'd96);
        checkOutput("de ticks per line", 32'(deCnt), 32'd640);

        // Mid-frame reset at x=300: outputs must clear without a clk edge.
        resetMain_n = 1'b0;
        #1;
        checkResetState("async reset");
        repeat (5) @(posedge clk);
        applyStimulus(1'b1, 1'b0);
        nextPixel(cyc, ok);
        checkOutput("restart pix_ce seen", 32'(ok), 32'd1);
        checkOutput("restart latency", 32'(cyc), 32'd4);
        checkOutput("restart x", 32'(vgaMain.x), 32'd0);
        checkOutput("restart y", 32'(vgaMain.y), 32'd0);
        checkOutput("restart de", 32'(vgaMain.de), 32'd1);
        checkOutput("restart frame_start", 32'(vgaMain.frame_start), 32'd1);

        // Small CLK_DIV=1 instance: reference model per clk from release.
        checkOutput("small reset hsync", 32'(vgaSmall.hsync), 32'd1);
        checkOutput("small reset pix_ce", 32'(vgaSmall.pix_ce), 32'd0);
        applyStimulus(1'b0, 1'b1);
        rasterErr = 0; ceErr = 0; fsCnt = 0; vsLow = 0;
        for (int k = 0; k <= 450; k++) begin
            @(posedge clk);
            #1;
            h = k % 15;
            v = (k / 15) % 10;
`ifdef VGA_FRAME_CNT_EN
            expFc = k / 150;
`else
            expFc = 0;
`endif
            expDe = (h < 8) && (v < 6);
            expHs = !((h >= 10) && (h < 13));
            expVs = !((v >= 7) && (v < 9));
            expLs = (h == 0);
            expFs = (h == 0) && (v == 0);
            if (vgaSmall.x !== 10'(h) || vgaSmall.y !== 10'(v) || vgaSmall.de !== expDe ||
                vgaSmall.hsync !== expHs || vgaSmall.vsync !== expVs ||
                vgaSmall.line_start !== expLs || vgaSmall.frame_start !== expFs ||
                vgaSmall.frame_cnt !== 16'(expFc))
                rasterErr++;
            if (vgaSmall.pix_ce !== 1'b1) ceErr++;
            if (k < 450) begin
                if (vgaSmall.frame_start === 1'b1) fsCnt++;
                if (vgaSmall.vsync === 1'b0) vsLow++;
            end
            if (k == 149) begin
                checkOutput("small last x", 32'(vgaSmall.x), 32'd14);
                checkOutput("small last y", 32'(vgaSmall.y), 32'd9);
            end
            if (k == 150) begin
                checkOutput("small y wrap", 32'(vgaSmall.y), 32'd0);
                checkOutput("small wrap frame_start", 32'(vgaSmall.frame_start), 32'd1);
            end
            if (k == 450) begin
`ifdef VGA_FRAME_CNT_EN
                checkOutput("frame_cnt after 3 frames", 32'(vgaSmall.frame_cnt), 32'd3);
`else
                checkOutput("frame_cnt tied off", 32'(vgaSmall.frame_cnt), 32'd0);
`endif
            end
        end
        checkOutput("small raster model cycles off", 32'(rasterErr), 32'd0);
        checkOutput("small pix_ce low cycles", 32'(ceErr), 32'd0);
        checkOutput("small frame_start pulses", 32'(fsCnt), 32'd3);
        checkOutput("small vsync low clks", 32'(vsLow), 32'd90);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
